key_draw_engine: RTL and testbench
==================================

# key_draw_engine

Parametrised pixel-drawing engine that renders a row of synthesizer keys and feeds the VGA adapter's `x`/`y`/`colour`/`plot` inputs at one pixel per clock. After reset it clears the screen, draws every key, then redraws only keys whose pressed state changed. It sits between the key/switch inputs and `vga_adapter` in the synth top level. It replaces hand-wired plotting with a generalised screen size, colour depth and key count.

## Interface
- `SCREEN_W`, 160: screen width in pixels.
- `SCREEN_H`, 120: screen height in pixels.
- `X_W`, 8: width of the x coordinate.
- `Y_W`, 7: width of the y coordinate.
- `COLOUR_W`, 3: colour width, matching the adapter's colour bits.
- `NUM_KEYS`, 10: number of keys drawn.
- `KEY_WIDTH`, 16: key width in pixels.
- `KEY_HEIGHT`, 40: key height in pixels.
- `KEY_X0`, 0: left edge of key 0.
- `KEY_Y0`, 80: top edge of all keys.
- `BG_COLOUR`, 3'b000: screen-clear colour.
- `IDLE_COLOUR`, 3'b111: colour of a released key.
- `PRESSED_COLOUR`, 3'b100: colour of a pressed key.
- `BORDER_COLOUR`, 3'b001: colour of the key border column.

Ports:
- `clock`  in  1  system clock (CLOCK_50).
- `resetn`  in  1  asynchronous, active-low reset.
- `keys`  in  NUM_KEYS  key pressed state, 1 = pressed; already synchronised to `clock`.
- `x`  out  X_W  pixel x, registered.
- `y`  out  Y_W  pixel y, registered.
- `colour`  out  COLOUR_W  pixel colour, registered.
- `plot`  out  1  pixel write strobe, one pixel per high cycle.
- `busy`  out  1  high whenever the FSM is not in IDLE.

Elaboration-time requirements:
- `KEY_X0 + NUM_KEYS*KEY_WIDTH <= SCREEN_W`.
- `KEY_Y0 + KEY_HEIGHT <= SCREEN_H`.

## Operation
The FSM has four states: CLEAR, SCAN, DRAW and IDLE.

Registers:
- `drawn[NUM_KEYS]`: key state last rendered.
- `pending[NUM_KEYS]`: keys awaiting redraw.
- `dx`, `dy`: pixel counters within the current area.
- `cur_key`: index of the key being drawn.
- `cur_col`: latched key colour.

State behaviour:
- **CLEAR** (entered on reset)
  - Raster-scans the whole screen, x fastest, with `colour=BG_COLOUR`: (0,0),(1,0)…(SCREEN_W-1,SCREEN_H-1).
  - After the last pixel: `pending` = all ones, `drawn` = all zeros, next state SCAN.
- **SCAN** (one cycle, `plot=0`)
  - Selects the lowest set bit k of `pending`, clears `pending[k]` and sets `drawn[k]=keys[k]`.
  - Sets `cur_col` = PRESSED_COLOUR if `keys[k]`, else IDLE_COLOUR; next state DRAW.
  - If `pending` is zero, next state is IDLE instead.
- **DRAW**
  - Raster-scans `x = KEY_X0 + k*KEY_WIDTH + dx` and `y = KEY_Y0 + dy`, with dx 0..KEY_WIDTH-1 fastest, then dy 0..KEY_HEIGHT-1.
  - Pixel colour is `cur_col`, except as modified under Configuration.
  - After pixel (KEY_WIDTH-1, KEY_HEIGHT-1), next state is SCAN.
- **IDLE**
  - `plot=0`, `busy=0`.
  - Next state is SCAN when `pending` is non-zero.

Change detection and arithmetic:
- In SCAN, DRAW and IDLE, every cycle: `pending <= pending | (keys ^ drawn)`.
  - In SCAN, the bit being cleared takes precedence.
- A key that changes during its own redraw mismatches `drawn` and is queued again.
- A key that toggles and returns before being sampled is not redrawn.
- Simultaneous changes are served lowest index first.
- Coordinate arithmetic is performed at `X_W`/`Y_W` width; no wrap-around is legal given the elaboration-time requirements.
- `x`, `y` and `colour` hold their last value while `plot=0`.

## Timing
- Reset values: `x=0`, `y=0`, `colour=0`, `plot=0`, `busy=1`, state CLEAR, `pending=0`, `drawn=0`.
- Asserting `resetn` low at any time, including mid-DRAW, forces these values immediately. After release, a full CLEAR restarts.
- First CLEAR plot appears on the first rising edge after `resetn` rises.
- CLEAR lasts exactly SCREEN_W*SCREEN_H plot cycles.
- Each key costs 1 SCAN cycle plus KEY_WIDTH*KEY_HEIGHT consecutive plot cycles.
- From a `keys` change sampled at edge N in IDLE:
  - `pending` is set at edge N.
  - SCAN occurs in cycle N+1.
  - First plot appears at edge N+2.
- `busy` falls in the same cycle IDLE is entered.

## Configuration
- `KEY_DRAW_BORDER_EN` defined:
  - The rightmost key column (dx==KEY_WIDTH-1) and the top row (dy==0) are drawn in BORDER_COLOUR.
  - All other key pixels use `cur_col`.
- Undefined: every key pixel uses `cur_col`.
- Cycle counts are identical in both builds.

## Test plan
- Reset with `keys=0`:
  - Exactly 19200 CLEAR plots with colour 000, ending at (159,119).
  - Then keys 0..9 are drawn in order, 640 plots each at colour 111.
  - `busy` falls after 19200+10*641 cycles.
- From IDLE, set `keys[3]=1`:
  - Plots cover x 48..63, y 80..119 in raster order, colour 100.
  - With `KEY_DRAW_BORDER_EN`, x=63 or y=80 pixels have colour 001.
  - First plot appears 2 cycles after the change.
- Set `keys[7]` and `keys[2]` in the same cycle: key 2 is fully redrawn, then after one SCAN cycle, key 7.
- Toggle `keys[5]` 1→0 midway through its own redraw: a second redraw of key 5 at colour 111 follows immediately.
- Pull `resetn` low mid-DRAW of key 4: `plot=0` and `busy=1` with no clock edge; after release, CLEAR restarts at (0,0).
- Override to NUM_KEYS=4, KEY_WIDTH=40, KEY_X0=0: the key 3 redraw spans x 120..159 with no out-of-range coordinate.

Source files
------------

// File: rtl/key_draw_engine.sv
// Pixel-drawing engine: clears the screen, draws a row of keys, then redraws only keys whose state changed.
// Optional build macro KEY_DRAW_BORDER_EN draws the right column and top row of each key in BORDER_COLOUR.
module key_draw_engine #(
    parameter int unsigned          SCREEN_W       = 160,
    parameter int unsigned          SCREEN_H       = 120,
    parameter int unsigned          X_W            = 8,
    parameter int unsigned          Y_W            = 7,
    parameter int unsigned          COLOUR_W       = 3,
    parameter int unsigned          NUM_KEYS       = 10,
    parameter int unsigned          KEY_WIDTH      = 16,
    parameter int unsigned          KEY_HEIGHT     = 40,
    parameter int unsigned          KEY_X0         = 0,
    parameter int unsigned          KEY_Y0         = 80,
    parameter logic [COLOUR_W-1:0]  BG_COLOUR      = 3'b000,
    parameter logic [COLOUR_W-1:0]  IDLE_COLOUR    = 3'b111,
    parameter logic [COLOUR_W-1:0]  PRESSED_COLOUR = 3'b100,
    parameter logic [COLOUR_W-1:0]  BORDER_COLOUR  = 3'b001
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic [NUM_KEYS-1:0] keys,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy
);

    localparam int unsigned KEY_IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

    // Geometry must fit on screen and in the coordinate widths.
    if (KEY_X0 + NUM_KEYS * KEY_WIDTH > SCREEN_W) begin : g_bad_x
        $error("key row exceeds SCREEN_W");
    end
    if (KEY_Y0 + KEY_HEIGHT > SCREEN_H) begin : g_bad_y
        $error("key row exceeds SCREEN_H");
    end
    if (SCREEN_W > (1 << X_W) || SCREEN_H > (1 << Y_W)) begin : g_bad_w
        $error("coordinate widths too small for screen");
    end

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAW  = 2'd2,
        S_IDLE  = 2'd3
    } state_t;

    state_t                state, state_next;

    logic [NUM_KEYS-1:0]   drawn, drawn_n;
    logic [NUM_KEYS-1:0]   pending, pending_n;
    logic [X_W-1:0]        dx, dx_n;
    logic [Y_W-1:0]        dy, dy_n;
    logic [KEY_IDX_W-1:0]  cur_key, cur_key_n;
    logic [COLOUR_W-1:0]   cur_col, cur_col_n;

    logic [X_W-1:0]        x_n;
    logic [Y_W-1:0]        y_n;
    logic [COLOUR_W-1:0]   colour_n;
    logic                  plot_n;
    logic                  busy_n;

    logic [NUM_KEYS-1:0]   pending_merge_c;
    logic [KEY_IDX_W-1:0]  sel_c;
    logic                  clear_last_c;
    logic                  draw_last_c;
    logic                  dx_key_end_c;
    logic [X_W-1:0]        key_x_c;
    logic                  border_hit_c;

    assign pending_merge_c = pending | (keys ^ drawn);
    assign clear_last_c    = (dx == X_W'(SCREEN_W - 1)) && (dy == Y_W'(SCREEN_H - 1));
    assign dx_key_end_c    = (dx == X_W'(KEY_WIDTH - 1));
    assign draw_last_c     = dx_key_end_c && (dy == Y_W'(KEY_HEIGHT - 1));
    assign key_x_c         = X_W'(KEY_X0) + X_W'(cur_key) * X_W'(KEY_WIDTH);

`ifdef KEY_DRAW_BORDER_EN
    assign border_hit_c = dx_key_end_c || (dy == '0);
`else
    assign border_hit_c = 1'b0;
`endif

    // Lowest-index pending key wins.
    always_comb begin : pick_lowest
        sel_c = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel_c = KEY_IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin : state_reg
        if (!resetn) begin
            state <= S_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin : next_state_logic
        state_next = state;
        unique case (state)
            S_CLEAR: if (clear_last_c) state_next = S_SCAN;
            S_SCAN:  state_next = (pending == '0) ? S_IDLE : S_DRAW;
            S_DRAW:  if (draw_last_c) state_next = S_SCAN;
            S_IDLE:  if (pending_merge_c != '0) state_next = S_SCAN;
            default: state_next = S_CLEAR;
        endcase
    end

    // Next values for the pixel outputs and the drawing datapath.
    always_comb begin : output_logic
        x_n       = x;
        y_n       = y;
        colour_n  = colour;
        plot_n    = 1'b0;
        busy_n    = (state_next != S_IDLE);
        dx_n      = dx;
        dy_n      = dy;
        pending_n = pending;
        drawn_n   = drawn;
        cur_key_n = cur_key;
        cur_col_n = cur_col;
        unique case (state)
            S_CLEAR: begin
                plot_n   = 1'b1;
                x_n      = dx;
                y_n      = dy;
                colour_n = BG_COLOUR;
                if (dx == X_W'(SCREEN_W - 1)) begin
                    dx_n = '0;
                    dy_n = dy + Y_W'(1);
                end else begin
                    dx_n = dx + X_W'(1);
                end
                if (clear_last_c) begin
                    dx_n      = '0;
                    dy_n      = '0;
                    pending_n = '1;
                    drawn_n   = '0;
                end
            end
            S_SCAN: begin
                pending_n = pending_merge_c;
                if (pending != '0) begin
                    pending_n[sel_c] = 1'b0;
                    drawn_n[sel_c]   = keys[sel_c];
                    cur_key_n        = sel_c;
                    cur_col_n        = keys[sel_c] ? PRESSED_COLOUR : IDLE_COLOUR;
                    dx_n             = '0;
                    dy_n             = '0;
                end
            end
            S_DRAW: begin
                plot_n    = 1'b1;
                x_n       = key_x_c + dx;
                y_n       = Y_W'(KEY_Y0) + dy;
                colour_n  = border_hit_c ? BORDER_COLOUR : cur_col;
                pending_n = pending_merge_c;
                if (dx_key_end_c) begin
                    dx_n = '0;
                    dy_n = dy + Y_W'(1);
                end else begin
                    dx_n = dx + X_W'(1);
                end
                if (draw_last_c) begin
                    dy_n = '0;
                end
            end
            S_IDLE: begin
                pending_n = pending_merge_c;
            end
            default: begin
                plot_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin : datapath_reg
        if (!resetn) begin
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            plot    <= 1'b0;
            busy    <= 1'b1;
            dx      <= '0;
            dy      <= '0;
            pending <= '0;
            drawn   <= '0;
            cur_key <= '0;
            cur_col <= '0;
        end else begin
            x       <= x_n;
            y       <= y_n;
            colour  <= colour_n;
            plot    <= plot_n;
            busy    <= busy_n;
            dx      <= dx_n;
            dy      <= dy_n;
            pending <= pending_n;
            drawn   <= drawn_n;
            cur_key <= cur_key_n;
            cur_col <= cur_col_n;
        end
    end

endmodule

// File: tb/tb_key_draw_engine.sv
// Self-checking bench for key_draw_engine: default instance plus a 4-key / 40-pixel-wide instance,
// compared every cycle against a pixel-index reference model.
module tb_key_draw_engine;

    logic       clock = 1'b0;
    logic       resetn;
    logic [9:0] keys;
    logic [3:0] keys4;

    logic [7:0] x0, x4;
    logic [6:0] y0, y4;
    logic [2:0] c0, c4;
    logic       plot0, plot4, busy0, busy4;

    always #5 clock = ~clock;

    key_draw_engine u_dut (
        .clock (clock), .resetn (resetn), .keys (keys),
        .x (x0), .y (y0), .colour (c0), .plot (plot0), .busy (busy0)
    );

    key_draw_engine #(.NUM_KEYS(4), .KEY_WIDTH(40), .KEY_X0(0)) u_dut4 (
        .clock (clock), .resetn (resetn), .keys (keys4),
        .x (x4), .y (y4), .colour (c4), .plot (plot4), .busy (busy4)
    );

    int n_vec    = 0;
    int n_err    = 0;
    int cyc      = 0;
    int plots0   = 0;
    int fall_cyc = -1;
    logic busy0_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    // Reference model: one entry per instance, pixels derived from a linear pixel index.
    localparam int M_CLEAR = 0, M_SCAN = 1, M_DRAW = 2, M_IDLE = 3;
    int         m_mode [2];
    int         m_cnt  [2];
    int         m_key  [2];
    logic [9:0] m_pend [2];
    logic [9:0] m_drawn[2];
    logic [2:0] m_col  [2];
    int         e_x    [2];
    int         e_y    [2];
    logic [2:0] e_c    [2];
    logic       e_plot [2];
    logic       e_busy [2];

    function automatic int nk(input int i);
        return (i == 0) ? 10 : 4;
    endfunction

    function automatic int kwid(input int i);
        return (i == 0) ? 16 : 40;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = M_CLEAR; m_cnt[i] = 0; m_key[i] = 0;
            m_pend[i] = '0; m_drawn[i] = '0; m_col[i] = '0;
            e_x[i] = 0; e_y[i] = 0; e_c[i] = '0; e_plot[i] = 1'b0; e_busy[i] = 1'b1;
        end
    endtask

    task automatic model_step(input int i, input logic [9:0] k_in);
        logic [9:0] mask, merge;
        int kw, dx, dy, k;
        bit found;
        mask  = 10'((1 << nk(i)) - 1);
        merge = m_pend[i] | ((k_in ^ m_drawn[i]) & mask);
        e_plot[i] = 1'b0;
        case (m_mode[i])
            M_CLEAR: begin
                e_plot[i] = 1'b1;
                e_x[i] = m_cnt[i] % 160;
                e_y[i] = m_cnt[i] / 160;
                e_c[i] = 3'b000;
                m_cnt[i]++;
                if (m_cnt[i] == 160 * 120) begin
                    m_pend[i] = mask; m_drawn[i] = '0; m_mode[i] = M_SCAN; m_cnt[i] = 0;
                end
            end
            M_SCAN: begin
                if (m_pend[i] == '0) begin
                    m_pend[i] = merge;
                    m_mode[i] = M_IDLE;
                end else begin
                    k = 0; found = 1'b0;
                    for (int b = 0; b < nk(i); b++) begin
                        if (!found && m_pend[i][b]) begin k = b; found = 1'b1; end
                    end
                    m_pend[i]     = merge;
                    m_pend[i][k]  = 1'b0;
                    m_drawn[i][k] = k_in[k];
                    m_col[i]      = k_in[k] ? 3'b100 : 3'b111;
                    m_key[i]      = k;
                    m_cnt[i]      = 0;
                    m_mode[i]     = M_DRAW;
                end
            end
            M_DRAW: begin
                kw = kwid(i);
                dx = m_cnt[i] % kw;
                dy = m_cnt[i] / kw;
                e_plot[i] = 1'b1;
                e_x[i] = m_key[i] * kw + dx;
                e_y[i] = 80 + dy;
                e_c[i] = m_col[i];
`ifdef KEY_DRAW_BORDER_EN
                if (dx == kw - 1 || dy == 0) e_c[i] = 3'b001;
`endif
                m_cnt[i]++;
                m_pend[i] = merge;
                if (m_cnt[i] == kw * 40) m_mode[i] = M_SCAN;
            end
            default: begin
                m_pend[i] = merge;
                if (merge != '0) m_mode[i] = M_SCAN;
            end
        endcase
        e_busy[i] = (m_mode[i] != M_IDLE);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        if (!resetn) begin
            chk("rst_plot0", 32'(plot0), 32'(0));
            chk("rst_busy0", 32'(busy0), 32'(1));
            chk("rst_xy0", 32'({x0, y0, c0}), 32'(0));
            chk("rst_plot4", 32'(plot4), 32'(0));
            chk("rst_busy4", 32'(busy4), 32'(1));
        end else begin
            model_step(0, keys);
            model_step(1, {6'b0, keys4});
            chk("plot0",   32'(plot0), 32'(e_plot[0]));
            chk("busy0",   32'(busy0), 32'(e_busy[0]));
            chk("x0",      32'(x0),    32'(e_x[0]));
            chk("y0",      32'(y0),    32'(e_y[0]));
            chk("colour0", 32'(c0),    32'(e_c[0]));
            chk("plot4",   32'(plot4), 32'(e_plot[1]));
            chk("busy4",   32'(busy4), 32'(e_busy[1]));
            chk("x4",      32'(x4),    32'(e_x[1]));
            chk("y4",      32'(y4),    32'(e_y[1]));
            chk("colour4", 32'(c4),    32'(e_c[1]));
        end
        if (plot0) plots0++;
        if (busy0_prev && !busy0 && fall_cyc < 0) fall_cyc = cyc;
        busy0_prev = busy0;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((busy0 || busy4) && n < bound);
        chk("idle_timeout", 32'(busy0 | busy4), 32'(0));
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        cyc = 0;
        fall_cyc = -1;
        tick();
        chk("clr_first_plot", 32'(plot0), 32'(1));
        chk("clr_first_xy", 32'({x0, y0}), 32'(0));
        chk("clr_first_colour", 32'(c0), 32'(0));
        wait_idle(30000);
        chk("busy_fall_cycle", 32'(fall_cyc), 32'(19200 + 10 * 641 + 1));
    endtask

    initial begin
        resetn = 1'b0;
        keys = '0;
        keys4 = '0;
        busy0_prev = 1'b1;
        model_reset();
        repeat (3) tick();
        release_reset();

        // Single key press from IDLE: two cycles of latency to first plot.
        keys[3] = 1'b1;
        keys4[3] = 1'b1;
        tick();
        chk("k3_edge_plot", 32'(plot0), 32'(0));
        tick();
        chk("k3_scan_plot", 32'(plot0), 32'(0));
        tick();
        chk("k3_first_plot", 32'(plot0), 32'(1));
        chk("k3_first_x", 32'(x0), 32'(48));
        chk("k3_first_y", 32'(y0), 32'(80));
        chk("k4inst_first_x", 32'(x4), 32'(120));
        wait_idle(3000);

        // Two keys in one cycle.
        plots0 = 0;
        keys[2] = 1'b1;
        keys[7] = 1'b1;
        wait_idle(3000);
        chk("k27_plots", 32'(plots0), 32'(1280));

        // Key released half way through its own redraw.
        plots0 = 0;
        keys[5] = 1'b1;
        repeat (322) tick();
        keys[5] = 1'b0;
        wait_idle(3000);
        chk("k5_plots", 32'(plots0), 32'(1280));

        // Random key activity.
        repeat (3000) begin
            if ($urandom_range(0, 39) == 0) keys[$urandom_range(0, 9)] ^= 1'b1;
            if ($urandom_range(0, 79) == 0) keys4[$urandom_range(0, 3)] ^= 1'b1;
            tick();
        end
        wait_idle(20000);

        // Asynchronous reset in the middle of drawing key 4.
        keys[4] = ~keys[4];
        repeat (102) tick();
        chk("k4_mid_plot", 32'(plot0), 32'(1));
        chk("k4_mid_key", 32'(x0 >> 4), 32'(4));
        resetn = 1'b0;
        #2;
        chk("async_rst_plot", 32'(plot0), 32'(0));
        chk("async_rst_busy", 32'(busy0), 32'(1));
        chk("async_rst_x", 32'(x0), 32'(0));
        model_reset();
        repeat (3) tick();
        release_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
